alu_operand_sequencer: RTL and testbench



---
 rtl/alu_operand_sequencer_pkg.sv | 15 +
 rtl/alu_operand_sequencer_btn_debounce.sv | 44 ++++
 rtl/alu_operand_sequencer.sv | 116 +++++++++++
 tb/tb_alu_operand_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared widths and FSM encodings for the ALU operand sequencer.
package alu_operand_sequencer_pkg;

    localparam int unsigned W       = 4;
    localparam int unsigned STAGE_W = 3;

    typedef enum logic [STAGE_W-1:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

endpackage

// File: rtl/alu_operand_sequencer_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and
// a one-cycle pulse on each accepted 0->1 level change.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps operand A, operand B and opcode in from one switch bank on debounced
// presses, then captures the ALU result into a held display register.
module alu_operand_sequencer #(
    parameter int unsigned W               = alu_operand_sequencer_pkg::W,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw,
    input  logic         btn_step,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [W-1:0] alu_op,
    input  logic [W-1:0] alu_c,
    input  logic         alu_v,
    input  logic         alu_carry,
    output logic [W-1:0] res_c,
    output logic         res_v,
    output logic         res_carry,
    output logic         res_valid,
    output logic [2:0]   stage
);

    import alu_operand_sequencer_pkg::*;

    state_t state_q;
    state_t state_d;
    logic   press;
    logic   load_a;
    logic   load_b;
    logic   load_op;
    logic   capture;
    logic   clear_valid;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_step),
        .press (press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    // S_EXEC advances unconditionally, giving the ALU one full cycle to settle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A:     if (press) state_d = S_B;
            S_B:     if (press) state_d = S_OP;
            S_OP:    if (press) state_d = S_EXEC;
            S_EXEC:  state_d = S_SHOW;
            S_SHOW:  if (press) state_d = S_A;
            default: state_d = S_A;
        endcase
    end

    always_comb begin
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_op     = 1'b0;
        capture     = 1'b0;
        clear_valid = 1'b0;
        case (state_q)
            S_A:     load_a      = press;
            S_B:     load_b      = press;
            S_OP:    load_op     = press;
            S_EXEC:  capture     = 1'b1;
            S_SHOW:  clear_valid = press;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else begin
            if (load_a)  alu_a  <= sw;
            if (load_b)  alu_b  <= sw;
            if (load_op) alu_op <= sw;
        end
    end

    // Result fields persist across the next sequence; only res_valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_c     <= '0;
            res_v     <= 1'b0;
            res_carry <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (capture) begin
                res_c     <= alu_c;
                res_v     <= alu_v;
                res_carry <= alu_carry;
                res_valid <= 1'b1;
            end else if (clear_valid) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign stage = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a short debounce window and
// a behavioural 4-bit ALU closing the loop.
module tb_alu_operand_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned CW = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw = '0;
    logic         btn_step = 1'b0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_op;
    logic [W-1:0] alu_c;
    logic         alu_v;
    logic         alu_carry;
    logic [W-1:0] res_c;
    logic         res_v;
    logic         res_carry;
    logic         res_valid;
    logic [2:0]   stage;

    int checks = 0;
    int errors = 0;
    int exec_seen = 0;
    int stage_changes = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(
        .W               (W),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_step  (btn_step),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .alu_v     (alu_v),
        .alu_carry (alu_carry),
        .res_c     (res_c),
        .res_v     (res_v),
        .res_carry (res_carry),
        .res_valid (res_valid),
        .stage     (stage)
    );

    // Behavioural ALU: 0 add, 1 subtract (carry = no borrow), others AND.
    logic [W:0] wide;
    always_comb begin
        wide      = '0;
        alu_c     = '0;
        alu_v     = 1'b0;
        alu_carry = 1'b0;
        case (alu_op)
            4'd0: begin
                wide      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c     = wide[W-1:0];
                alu_carry = wide[W];
                alu_v     = (alu_a[W-1] == alu_b[W-1]) && (alu_c[W-1] != alu_a[W-1]);
            end
            4'd1: begin
                alu_c     = alu_a - alu_b;
                alu_carry = (alu_a >= alu_b);
                alu_v     = (alu_a[W-1] != alu_b[W-1]) && (alu_c[W-1] != alu_a[W-1]);
            end
            default: alu_c = alu_a & alu_b;
        endcase
    end

    // Advance n cycles, sampling at the falling edge.
    task automatic step(input int n);
        logic [2:0] prev;
        for (int i = 0; i < n; i++) begin
            prev = stage;
            @(negedge clk);
            if (stage == 3'd3) exec_seen++;
            if (stage != prev) stage_changes++;
        end
    endtask

    task automatic press_btn(input logic [W-1:0] val);
        sw = val;
        btn_step = 1'b1;
        step(DB + 6);
        btn_step = 1'b0;
        step(DB + 6);
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({alu_a, alu_b, alu_op, res_c} !== 16'h0 || res_v !== 1'b0 || res_carry !== 1'b0
            || res_valid !== 1'b0 || stage !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: a=%h b=%h op=%h c=%h v=%b cy=%b valid=%b stage=%0d, want all 0",
                     alu_a, alu_b, alu_op, res_c, res_v, res_carry, res_valid, stage);
        end
        step(2);
        rst = 1'b0;
        step(20);
        checks++;
        if (stage !== 3'd0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_stage: stage=%0d valid=%b, want 0 0", stage, res_valid);
        end
    endtask

    task automatic test_load_exec;
        press_btn(4'b0011);
        checks++;
        if (stage !== 3'd1 || alu_a !== 4'd3) begin
            errors++;
            $display("FAIL load_a: stage=%0d a=%h, want 1 3", stage, alu_a);
        end
        press_btn(4'b0101);
        checks++;
        if (stage !== 3'd2 || alu_b !== 4'd5 || alu_a !== 4'd3) begin
            errors++;
            $display("FAIL load_b: stage=%0d a=%h b=%h, want 2 3 5", stage, alu_a, alu_b);
        end
        exec_seen = 0;
        press_btn(4'b0000);
        checks++;
        if (exec_seen != 1) begin
            errors++;
            $display("FAIL exec_one_cycle: cycles in stage 3=%0d, want 1", exec_seen);
        end
        checks++;
        if (stage !== 3'd4 || alu_op !== 4'd0 || res_c !== 4'b1000 || res_v !== 1'b1
            || res_carry !== 1'b0 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_result: stage=%0d op=%h c=%b v=%b cy=%b valid=%b, want 4 0 1000 1 0 1",
                     stage, alu_op, res_c, res_v, res_carry, res_valid);
        end
    endtask

    task automatic test_show_return;
        press_btn(4'b1111);
        checks++;
        if (stage !== 3'd0 || res_valid !== 1'b0 || alu_a !== 4'd3 || res_c !== 4'b1000
            || res_v !== 1'b1) begin
            errors++;
            $display("FAIL show_return: stage=%0d valid=%b a=%h c=%b v=%b, want 0 0 3 1000 1",
                     stage, res_valid, alu_a, res_c, res_v);
        end
    endtask

    task automatic test_bouncy;
        sw = 4'b0011;
        stage_changes = 0;
        for (int i = 0; i < 5; i++) begin
            btn_step = ~btn_step;
            step(2);
        end
        btn_step = 1'b1;
        step(8);
        btn_step = 1'b0;
        step(DB + 6);
        checks++;
        if (stage !== 3'd1 || stage_changes != 1 || alu_a !== 4'd3) begin
            errors++;
            $display("FAIL bouncy_press: stage=%0d changes=%0d a=%h, want 1 1 3",
                     stage, stage_changes, alu_a);
        end
    endtask

    task automatic test_glitch;
        sw = 4'b1010;
        btn_step = 1'b1;
        step(3);
        btn_step = 1'b0;
        step(10);
        checks++;
        if (stage !== 3'd1 || alu_b !== 4'd5) begin
            errors++;
            $display("FAIL glitch: stage=%0d b=%h, want 1 5", stage, alu_b);
        end
        press_btn(4'b0101);
        checks++;
        if (stage !== 3'd2 || alu_a !== 4'd3 || alu_b !== 4'd5) begin
            errors++;
            $display("FAIL reach_op: stage=%0d a=%h b=%h, want 2 3 5", stage, alu_a, alu_b);
        end
    endtask

    task automatic test_reset_mid;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, res_c} !== 16'h0 || res_v !== 1'b0 || res_carry !== 1'b0
            || res_valid !== 1'b0 || stage !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: a=%h b=%h op=%h c=%h v=%b cy=%b valid=%b stage=%0d, want all 0",
                     alu_a, alu_b, alu_op, res_c, res_v, res_carry, res_valid, stage);
        end
        step(2);
        rst = 1'b0;
        step(2);
        press_btn(4'b0111);
        checks++;
        if (stage !== 3'd1 || alu_a !== 4'd7 || alu_b !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_load: stage=%0d a=%h b=%h, want 1 7 0", stage, alu_a, alu_b);
        end
    endtask

    task automatic test_back_to_back;
        press_btn(4'b0010);
        exec_seen = 0;
        press_btn(4'b0001);
        checks++;
        if (exec_seen != 1 || stage !== 3'd4) begin
            errors++;
            $display("FAIL sub_exec: exec cycles=%0d stage=%0d, want 1 4", exec_seen, stage);
        end
        checks++;
        if (res_c !== 4'd5 || res_v !== 1'b0 || res_carry !== 1'b1 || res_valid !== 1'b1
            || alu_op !== 4'd1) begin
            errors++;
            $display("FAIL sub_result: c=%h v=%b cy=%b valid=%b op=%h, want 5 0 1 1 1",
                     res_c, res_v, res_carry, res_valid, alu_op);
        end
    endtask

    initial begin
        test_reset;
        test_load_exec;
        test_show_return;
        test_bouncy;
        test_glitch;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
